// File: rtl/pes_param_counter_if.sv
// Control and pad-side signal bundle for pes_param_counter.
// The master drives the counter controls, and the slave (the counter) drives the pads.
interface pes_param_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  up_dn;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      io_out;
  logic [WIDTH-1:0]      io_oeb;
  logic                  tc_o;
  logic                  halted_o;

  modport master (
    output en, up_dn, mode, prescale, load, load_val,
    input  io_out, io_oeb, tc_o, halted_o
  );

  modport slave (
    input  en, up_dn, mode, prescale, load, load_val,
    output io_out, io_oeb, tc_o, halted_o
  );
endinterface

// File: rtl/pes_param_counter.sv
// WIDTH-bit up/down counter with prescaler, parallel load, and wrap/saturate/one-shot terminal
// behaviour. It drives the user GPIO pads directly.
module pes_param_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  pes_param_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      oeb_q, oeb_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tc_q, tc_d;
  logic                  halted_q, halted_d;
  logic                  tick;
  logic                  at_term;
  mode_e                 mode;

  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] v, input logic up);
    return up ? v + WIDTH'(1) : v - WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_value(input logic up);
    return up ? '0 : '1;
  endfunction

  assign mode = mode_e'(bus.mode);

  // ">=" lets a mid-count reduction of prescale fire on the next enabled cycle.
  assign tick    = bus.en & ~halted_q & (pre_cnt_q >= bus.prescale);
  assign at_term = bus.up_dn ? (cnt_q == '1) : (cnt_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    pre_cnt_d = pre_cnt_q;
    halted_d  = halted_q;
    tc_d      = 1'b0;
    oeb_d     = '0;
    if (bus.load) begin
      cnt_d     = bus.load_val;
      pre_cnt_d = '0;
      halted_d  = 1'b0;
    end else if (tick) begin
      pre_cnt_d = '0;
      if (!at_term) begin
        cnt_d = step_count(cnt_q, bus.up_dn);
      end else begin
        tc_d = 1'b1;
        case (mode)
          MODE_SAT:     cnt_d = cnt_q;
          MODE_ONESHOT: halted_d = 1'b1;
          default:      cnt_d = wrap_value(bus.up_dn);
        endcase
      end
    end else if (bus.en && !halted_q) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
      halted_q  <= 1'b0;
      oeb_q     <= '1;
    end else begin
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      halted_q  <= halted_d;
      oeb_q     <= oeb_d;
    end
  end

  assign bus.io_out   = cnt_q;
  assign bus.io_oeb   = oeb_q;
  assign bus.tc_o     = tc_q;
  assign bus.halted_o = halted_q;

endmodule

// File: tb/tb_pes_param_counter.sv
// Scenario bench for pes_param_counter (WIDTH=8, PRESCALE_W=4).
// Expected outputs are queued as stimulus is applied and compared after each edge.
module tb_pes_param_counter;

  logic clk = 1'b0;
  logic wb_rst;

  pes_param_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

  pes_param_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic [7:0] oeb;
    logic       tc;
    logic       halt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_cnt, m_oeb;
  logic [3:0] m_pre;
  logic       m_tc, m_halt;

  // Drive one cycle of stimulus, advance the reference, queue its expectation, and pass the edge.
  task automatic cyc(input logic r, input logic e, input logic u, input logic [1:0] m,
                     input logic [3:0] ps, input logic ld, input logic [7:0] lv);
    exp_t x;
    logic term;
    wb_rst = r; bus.en = e; bus.up_dn = u; bus.mode = m;
    bus.prescale = ps; bus.load = ld; bus.load_val = lv;
    if (r) begin
      m_cnt = 8'h00; m_pre = 4'd0; m_tc = 1'b0; m_halt = 1'b0; m_oeb = 8'hFF;
    end else begin
      m_oeb = 8'h00;
      m_tc  = 1'b0;
      if (ld) begin
        m_cnt = lv; m_pre = 4'd0; m_halt = 1'b0;
      end else if (e && !m_halt && (m_pre >= ps)) begin
        m_pre = 4'd0;
        term  = u ? (m_cnt == 8'hFF) : (m_cnt == 8'h00);
        if (!term) m_cnt = u ? m_cnt + 8'd1 : m_cnt - 8'd1;
        else begin
          m_tc = 1'b1;
          if (m == 2'b10) m_halt = 1'b1;
          else if (m != 2'b01) m_cnt = u ? 8'h00 : 8'hFF;
        end
      end else if (e && !m_halt) begin
        m_pre = m_pre + 4'd1;
      end
    end
    x.out = m_cnt; x.oeb = m_oeb; x.tc = m_tc; x.halt = m_halt;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cyc((i < 2), 1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 8'h00);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL reset[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      total++;
      if (bus.io_oeb !== ((i < 2) ? 8'hFF : 8'h00)) begin
        bad++;
        $display("FAIL reset_oeb[%0d] got %h want %h", i, bus.io_oeb, (i < 2) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    int   tc_seen = 0;
    for (int i = 1; i <= 260; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 8'h00);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL wrap[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      if (bus.tc_o === 1'b1) tc_seen++;
      if (i == 256) begin
        total++;
        if (bus.io_out !== 8'h00 || bus.tc_o !== 1'b1) begin
          bad++;
          $display("FAIL wrap_point got out=%h tc=%b want out=00 tc=1", bus.io_out, bus.tc_o);
        end
      end
    end
    total++;
    if (tc_seen != 1 || bus.io_out !== 8'h04) begin
      bad++;
      $display("FAIL wrap_summary got tc_pulses=%0d out=%h want tc_pulses=1 out=04", tc_seen, bus.io_out);
    end
  endtask

  task automatic test_prescale;
    exp_t e;
    logic en_v;
    logic [7:0] want;
    // 1 reset cycle, 6 enabled, 5 disabled, 2 enabled.
    for (int i = 0; i < 14; i++) begin
      en_v = (i >= 1 && i <= 6) || (i >= 12);
      cyc((i == 0), en_v, 1'b1, 2'b00, 4'd3, 1'b0, 8'h00);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL prescale[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      want = (i < 4) ? 8'h00 : (i < 13) ? 8'h01 : 8'h02;
      total++;
      if (bus.io_out !== want) begin
        bad++;
        $display("FAIL prescale_phase[%0d] got out=%h want %h", i, bus.io_out, want);
      end
    end
  endtask

  task automatic test_saturate;
    exp_t e;
    for (int i = 0; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 4'd0, (i == 0), 8'h05);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL saturate[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      total++;
      if (bus.io_out !== ((i <= 5) ? 8'(5 - i) : 8'h00) || bus.tc_o !== (i > 5) || bus.halted_o !== 1'b0) begin
        bad++;
        $display("FAIL saturate_seq[%0d] got out=%h tc=%b halt=%b", i, bus.io_out, bus.tc_o, bus.halted_o);
      end
    end
  endtask

  task automatic test_oneshot;
    exp_t e;
    logic [7:0] want;
    // 0 load FD, 1..3 ticks, 4..9 halted with en toggling and mode changes, 10 load 10, 11 tick.
    for (int i = 0; i <= 11; i++) begin
      cyc(1'b0, (i < 4 || i >= 10) ? 1'b1 : i[0], 1'b1, (i >= 6 && i < 10) ? 2'b00 : 2'b10,
          4'd0, (i == 0 || i == 10), (i == 0) ? 8'hFD : 8'h10);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL oneshot[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      want = (i == 0) ? 8'hFD : (i == 1) ? 8'hFE : (i < 10) ? 8'hFF : (i == 10) ? 8'h10 : 8'h11;
      total++;
      if (bus.io_out !== want || bus.tc_o !== (i == 3) || bus.halted_o !== (i >= 3 && i < 10)) begin
        bad++;
        $display("FAIL oneshot_seq[%0d] got out=%h tc=%b halt=%b want out=%h", i, bus.io_out, bus.tc_o,
                 bus.halted_o, want);
      end
    end
  endtask

  task automatic test_corners;
    exp_t e;
    // Load colliding with a terminal tick in saturate mode.
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 4'd0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 4'd0, 1'b1, 8'h33);
    // Mode 11 behaves as wrap.
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      total++;
      if (e.out !== ((i == 0) ? 8'hFF : (i == 1) ? 8'h33 : (i == 2) ? 8'hFF : 8'h00) || e.tc !== (i == 3)) begin
        bad++;
        $display("FAIL corner_model[%0d] got out=%h tc=%b", i, e.out, e.tc);
      end
    end
    total++;
    if (bus.io_out !== 8'h00 || bus.tc_o !== 1'b1) begin
      bad++;
      $display("FAIL mode3_wrap got out=%h tc=%b want out=00 tc=1", bus.io_out, bus.tc_o);
    end
    // Lower prescale from 15 to 2 once pre_cnt has reached 9.
    for (int i = 0; i <= 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 2'b00, (i == 10) ? 4'd2 : 4'd15, (i == 0), 8'h00);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL prescale_drop[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      total++;
      if (bus.io_out !== ((i == 10) ? 8'h01 : 8'h00)) begin
        bad++;
        $display("FAIL prescale_drop_out[%0d] got %h want %h", i, bus.io_out, (i == 10) ? 8'h01 : 8'h00);
      end
    end
    // Reach halted (one-shot down from 01), then reset; then reset again at 0x7A.
    for (int i = 0; i < 7; i++) begin
      cyc((i == 3 || i == 5), (i < 3), 1'b0, 2'b10, 4'd0, (i == 0 || i == 4), (i == 0) ? 8'h01 : 8'h7A);
      e = sb.pop_front();
      total++;
      if ({bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {e.out, e.oeb, e.tc, e.halt}) begin
        bad++;
        $display("FAIL reset_mid[%0d] got out=%h oeb=%h tc=%b halt=%b want out=%h oeb=%h tc=%b halt=%b",
                 i, bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o, e.out, e.oeb, e.tc, e.halt);
      end
      if (i == 2 || i == 3 || i == 5 || i == 6) begin
        total++;
        if ((i == 2 && {bus.tc_o, bus.halted_o} !== 2'b11) ||
            ((i == 3 || i == 5) && {bus.io_out, bus.io_oeb, bus.tc_o, bus.halted_o} !== {8'h00, 8'hFF, 2'b00}) ||
            (i == 6 && bus.io_oeb !== 8'h00)) begin
          bad++;
          $display("FAIL reset_mid_fixed[%0d] got out=%h oeb=%h tc=%b halt=%b", i, bus.io_out, bus.io_oeb,
                   bus.tc_o, bus.halted_o);
        end
      end
    end
  endtask

  initial begin
    wb_rst = 1'b1;
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.mode = 2'b00;
    bus.prescale = 4'd0; bus.load = 1'b0; bus.load_val = 8'h00;
    m_cnt = 8'h00; m_oeb = 8'hFF; m_pre = 4'd0; m_tc = 1'b0; m_halt = 1'b0;
    test_reset;
    test_wrap;
    test_prescale;
    test_saturate;
    test_oneshot;
    test_corners;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
